alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Request-driven sequencer that sits in front of the TotalALU datapath and drives its `dataA`/`dataB`/`Signal` inputs, sampling its `Output`. It accepts one operation at a time over a valid/ready request channel. It issues single-cycle funct codes directly and runs the MULTU/DIVU multi-cycle path followed by MFHI/MFLO readback. It returns a 64-bit result over a valid/ready response channel.

## Interface
- `MUL_CYCLES`, default 32: cycles `alu_signal` is held at MULTU/DIVU before readback.
- `ALU_LAT`, default 1: cycles from the end of a funct issue cycle to the edge at which `alu_result` is sampled.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer can accept.
- `req_funct`  in  6  funct code (AND 36, OR 37, ADD 32, SUB 34, SLT 42, SRL 2, MULTU 25, DIVU 27).
- `req_a`, `req_b`  in  32  operands.
- `alu_dataA`, `alu_dataB`  out  32  to TotalALU operands.
- `alu_signal`  out  6  to TotalALU `Signal`; 6'b000000 (no-op) when not issuing.
- `alu_result`  in  32  from TotalALU `Output`.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts.
- `rsp_hi`, `rsp_lo`  out  32  result; single-cycle ops put the result in `rsp_lo` and drive `rsp_hi`=0.
- `rsp_err`  out  1  unsupported funct.

## Operation
- Reset values: `req_ready`=0 while `reset` is high, then 1 in IDLE. `rsp_valid`=0. `rsp_hi`=`rsp_lo`=0. `rsp_err`=0. `alu_signal`=0. `alu_dataA`=`alu_dataB`=0. State=IDLE. Counter=0.
- States: IDLE, ISSUE, WAIT, MUL_RUN, RD_HI, WAIT_HI, RD_LO, WAIT_LO, RESP.
- IDLE: on `req_valid`&&`req_ready`, register operands and funct onto `alu_dataA`/`alu_dataB` (held until RESP). Then:
  - single-cycle funct → ISSUE;
  - MULTU/DIVU → MUL_RUN;
  - any other funct → RESP with `rsp_err`=1, `rsp_hi`=`rsp_lo`=0, no ALU activity.
- ISSUE: `alu_signal`=funct for exactly 1 cycle → WAIT.
- WAIT: `alu_signal`=0; count ALU_LAT cycles. At the last cycle's edge capture `alu_result` into `rsp_lo`, set `rsp_hi`=0 → RESP.
- MUL_RUN: `alu_signal`=funct for MUL_CYCLES consecutive cycles (counter 0..MUL_CYCLES-1) → RD_HI.
- RD_HI: `alu_signal`=6'b010000 (MFHI) for 1 cycle. Then WAIT_HI for ALU_LAT cycles, capture `alu_result` into `rsp_hi`.
- RD_LO: `alu_signal`=6'b010010 (MFLO) for 1 cycle. Then WAIT_LO for ALU_LAT cycles, capture `alu_result` into `rsp_lo` → RESP.
- RESP: `rsp_valid`=1. `rsp_hi`, `rsp_lo` and `rsp_err` are stable until `rsp_valid`&&`rsp_ready` → IDLE, `rsp_valid`=0, `rsp_err` cleared.
- `req_ready`=1 only in IDLE (see Configuration). No request is queued; the requester holds `req_*` stable while `req_ready`=0.
- Reset asserted in any state: all outputs go to reset values immediately (async). Any in-flight op is lost and no response is produced. TotalALU's HiLo contents are not this block's responsibility.

## Timing
- Handshake at edge ending cycle T.
- Single-cycle op: `alu_signal`=funct during T+1. `rsp_valid` rises in cycle T+2+ALU_LAT (T+3 by default).
- MULTU/DIVU: funct during T+1..T+MUL_CYCLES. MFHI at T+MUL_CYCLES+1. MFLO at T+MUL_CYCLES+2+ALU_LAT. `rsp_valid` in T+MUL_CYCLES+3+2·ALU_LAT (T+37 by default).
- Unsupported funct: `rsp_valid` in T+1.
- Minimum request spacing without the overlap option: response latency + 1 handshake cycle + 1 IDLE cycle.

## Configuration
- `ALU_SEQ_OVERLAP_EN` defined: in RESP, `req_ready`=`rsp_ready`. A request accepted on the same edge as the response handshake goes directly to ISSUE/MUL_RUN/RESP(err), skipping IDLE, and all response registers are overwritten per the new op.
- Undefined: `req_ready`=0 in RESP; a new request is accepted only from IDLE.

## Test plan
- ADD `req_a`=5, `req_b`=7, `rsp_ready`=1 → `alu_signal`=32 for 1 cycle at T+1; `rsp_valid` at T+3 with `rsp_lo`=12, `rsp_hi`=0, `rsp_err`=0.
- MULTU `req_a`=0xFFFFFFFF, `req_b`=2 → MULTU held for 32 cycles, MFHI then MFLO issued; `rsp_valid` at T+37 with `rsp_hi`=1, `rsp_lo`=0xFFFFFFFE.
- SUB 3−5 with `rsp_ready`=0 for 10 cycles → `rsp_lo`=0xFFFFFFFE held stable, `req_ready`=0 throughout; IDLE one cycle after `rsp_ready` rises.
- funct 6'b111111 → `rsp_valid` at T+1 with `rsp_err`=1, `rsp_hi`=`rsp_lo`=0; `alu_signal` stays 0.
- Reset pulse during MUL_RUN cycle 10 → `alu_signal`=0 and `rsp_valid`=0 immediately; no response; `req_ready`=1 after release.
- With `ALU_SEQ_OVERLAP_EN`: back-to-back AND 0xF0F0&0xFF00 then OR 1|2 → first response 0xF000, second request accepted on the same edge, second response 3 three cycles later.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if
// Groups the request channel, the TotalALU drive/sample lines and the
// response channel of alu_op_sequencer. The sequencer takes the slave
// modport. The requester/ALU environment takes the master modport.
interface alu_op_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_funct;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [31:0] alu_dataA;
  logic [31:0] alu_dataB;
  logic [5:0]  alu_signal;
  logic [31:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_hi;
  logic [31:0] rsp_lo;
  logic        rsp_err;

  modport slave (
    input  req_valid, req_funct, req_a, req_b, alu_result, rsp_ready,
    output req_ready, alu_dataA, alu_dataB, alu_signal, rsp_valid, rsp_hi, rsp_lo, rsp_err
  );

  modport master (
    output req_valid, req_funct, req_a, req_b, alu_result, rsp_ready,
    input  req_ready, alu_dataA, alu_dataB, alu_signal, rsp_valid, rsp_hi, rsp_lo, rsp_err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Accepts one operation at a time and drives the TotalALU. Single-cycle
// functs are issued for one cycle. MULTU/DIVU are held for MUL_CYCLES
// cycles, then HI and LO are read back with MFHI/MFLO. A 64-bit result is
// returned over a valid/ready response channel.
// Optional feature: define ALU_SEQ_OVERLAP_EN to let a new request be
// accepted on the same edge as the response handshake.
module alu_op_sequencer #(
  parameter int MUL_CYCLES = 32,
  parameter int ALU_LAT    = 1
) (
  input logic               clk,
  input logic               reset,
  alu_op_sequencer_if.slave bus
);

  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_SLT   = 6'd42;
  localparam logic [5:0] FN_SRL   = 6'd2;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_DIVU  = 6'd27;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_NOP   = 6'b000000;

  localparam int              CNT_W    = 16;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(ALU_LAT - 1);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    ISSUE   = 4'd1,
    WAIT    = 4'd2,
    MUL_RUN = 4'd3,
    RD_HI   = 4'd4,
    WAIT_HI = 4'd5,
    RD_LO   = 4'd6,
    WAIT_LO = 4'd7,
    RESP    = 4'd8
  } state_t;

  function automatic logic isSingle(input logic [5:0] f);
    case (f)
      FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT, FN_SRL: isSingle = 1'b1;
      default:                                       isSingle = 1'b0;
    endcase
  endfunction

  function automatic logic isMul(input logic [5:0] f);
    case (f)
      FN_MULTU, FN_DIVU: isMul = 1'b1;
      default:           isMul = 1'b0;
    endcase
  endfunction

  // First state of an accepted op. Unsupported functs go straight to an error response.
  function automatic state_t entryState(input logic [5:0] f);
    if (isSingle(f)) begin
      entryState = ISSUE;
    end else if (isMul(f)) begin
      entryState = MUL_RUN;
    end else begin
      entryState = RESP;
    end
  endfunction

  // Value on the ALU Signal lines while in a given state.
  function automatic logic [5:0] signalFor(input state_t s, input logic [5:0] f);
    case (s)
      ISSUE, MUL_RUN: signalFor = f;
      RD_HI:          signalFor = FN_MFHI;
      RD_LO:          signalFor = FN_MFLO;
      default:        signalFor = FN_NOP;
    endcase
  endfunction

  state_t           state_r;
  state_t           nextState_s;
  logic [CNT_W-1:0] cnt_r;
  logic             cntDone_s;
  logic [5:0]       funct_r;
  logic [5:0]       nextFunct_s;
  logic [31:0]      dataA_r;
  logic [31:0]      dataB_r;
  logic [5:0]       aluSignal_r;
  logic             rspValid_r;
  logic [31:0]      rspHi_r;
  logic [31:0]      rspLo_r;
  logic             rspErr_r;
  logic             reqReady_s;
  logic             accept_s;
  logic             rspHs_s;
  logic             newErr_s;

  // Ready is high only when a new op can start, and never while reset is held.
  always_comb begin
    reqReady_s = 1'b0;
    if (reset) begin
      reqReady_s = 1'b0;
    end else if (state_r == IDLE) begin
      reqReady_s = 1'b1;
`ifdef ALU_SEQ_OVERLAP_EN
    end else if (state_r == RESP) begin
      reqReady_s = bus.rsp_ready;
`endif
    end else begin
      reqReady_s = 1'b0;
    end
  end

  assign accept_s    = bus.req_valid && reqReady_s;
  assign rspHs_s     = (state_r == RESP) && bus.rsp_ready;
  assign newErr_s    = accept_s && !isSingle(bus.req_funct) && !isMul(bus.req_funct);
  assign nextFunct_s = accept_s ? bus.req_funct : funct_r;

  // Terminal-count detect for the multiply hold and the ALU latency waits.
  always_comb begin
    cntDone_s = 1'b0;
    case (state_r)
      MUL_RUN:               cntDone_s = (cnt_r == MUL_LAST);
      WAIT, WAIT_HI, WAIT_LO: cntDone_s = (cnt_r == LAT_LAST);
      default:               cntDone_s = 1'b0;
    endcase
  end

  // Next-state decode.
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) nextState_s = entryState(bus.req_funct);
        else          nextState_s = IDLE;
      end
      ISSUE:   nextState_s = WAIT;
      WAIT: begin
        if (cntDone_s) nextState_s = RESP;
        else           nextState_s = WAIT;
      end
      MUL_RUN: begin
        if (cntDone_s) nextState_s = RD_HI;
        else           nextState_s = MUL_RUN;
      end
      RD_HI:   nextState_s = WAIT_HI;
      WAIT_HI: begin
        if (cntDone_s) nextState_s = RD_LO;
        else           nextState_s = WAIT_HI;
      end
      RD_LO:   nextState_s = WAIT_LO;
      WAIT_LO: begin
        if (cntDone_s) nextState_s = RESP;
        else           nextState_s = WAIT_LO;
      end
      RESP: begin
        if (accept_s)     nextState_s = entryState(bus.req_funct);
        else if (rspHs_s) nextState_s = IDLE;
        else              nextState_s = RESP;
      end
      default: nextState_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= nextState_s;
  end

  // Cycle counter: restarts on every state change, advances only in counting states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (nextState_s != state_r) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == MUL_RUN) || (state_r == WAIT) ||
                 (state_r == WAIT_HI) || (state_r == WAIT_LO)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Latch funct and operands at acceptance; operands stay on the ALU inputs until the next op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      funct_r <= 6'd0;
      dataA_r <= 32'd0;
      dataB_r <= 32'd0;
    end else if (accept_s) begin
      funct_r <= bus.req_funct;
      dataA_r <= bus.req_a;
      dataB_r <= bus.req_b;
    end else begin
      funct_r <= funct_r;
      dataA_r <= dataA_r;
      dataB_r <= dataB_r;
    end
  end

  // ALU Signal and response-valid are registered from the upcoming state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aluSignal_r <= FN_NOP;
      rspValid_r  <= 1'b0;
    end else begin
      aluSignal_r <= signalFor(nextState_s, nextFunct_s);
      rspValid_r  <= (nextState_s == RESP);
    end
  end

  // Response payload: error marking at acceptance, result capture at the end of each wait.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rspHi_r  <= 32'd0;
      rspLo_r  <= 32'd0;
      rspErr_r <= 1'b0;
    end else if (newErr_s) begin
      rspHi_r  <= 32'd0;
      rspLo_r  <= 32'd0;
      rspErr_r <= 1'b1;
    end else if (accept_s) begin
      rspErr_r <= 1'b0;
    end else if ((state_r == WAIT) && cntDone_s) begin
      rspHi_r <= 32'd0;
      rspLo_r <= bus.alu_result;
    end else if ((state_r == WAIT_HI) && cntDone_s) begin
      rspHi_r <= bus.alu_result;
    end else if ((state_r == WAIT_LO) && cntDone_s) begin
      rspLo_r <= bus.alu_result;
    end else if (rspHs_s) begin
      rspErr_r <= 1'b0;
    end else begin
      rspHi_r  <= rspHi_r;
      rspLo_r  <= rspLo_r;
      rspErr_r <= rspErr_r;
    end
  end

  assign bus.req_ready  = reqReady_s;
  assign bus.alu_dataA  = dataA_r;
  assign bus.alu_dataB  = dataB_r;
  assign bus.alu_signal = aluSignal_r;
  assign bus.rsp_valid  = rspValid_r;
  assign bus.rsp_hi     = rspHi_r;
  assign bus.rsp_lo     = rspLo_r;
  assign bus.rsp_err    = rspErr_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
// Directed vector table, reset-abort and (optionally) overlap sequences, then
// randomized ops checked against an arithmetic reference model. A small
// registered TotalALU model with HI/LO answers the sequencer.
module tb_alu_op_sequencer;

  localparam int MUL = 32;
  localparam int LAT = 1;

  logic clk;
  logic reset;
  int   testsRun = 0;
  int   failed   = 0;

  alu_op_sequencer_if bus();

  alu_op_sequencer #(.MUL_CYCLES(MUL), .ALU_LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // TotalALU stand-in: registered Output, HI/LO written by MULTU/DIVU.
  logic [31:0] aluOut = 32'd0;
  logic [31:0] aluHi  = 32'd0;
  logic [31:0] aluLo  = 32'd0;
  always @(posedge clk) begin
    case (bus.alu_signal)
      6'd36: aluOut <= bus.alu_dataA & bus.alu_dataB;
      6'd37: aluOut <= bus.alu_dataA | bus.alu_dataB;
      6'd32: aluOut <= bus.alu_dataA + bus.alu_dataB;
      6'd34: aluOut <= bus.alu_dataA - bus.alu_dataB;
      6'd42: aluOut <= ($signed(bus.alu_dataA) < $signed(bus.alu_dataB)) ? 32'd1 : 32'd0;
      6'd2:  aluOut <= bus.alu_dataA >> bus.alu_dataB[4:0];
      6'd25: {aluHi, aluLo} <= {32'd0, bus.alu_dataA} * {32'd0, bus.alu_dataB};
      6'd27: begin
        if (bus.alu_dataB != 32'd0) begin
          aluHi <= bus.alu_dataA % bus.alu_dataB;
          aluLo <= bus.alu_dataA / bus.alu_dataB;
        end
      end
      6'd16: aluOut <= aluHi;
      6'd18: aluOut <= aluLo;
      default: aluOut <= aluOut;
    endcase
  end
  assign bus.alu_result = aluOut;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference: {err, hi, lo} straight from the operation definitions.
  function automatic logic [64:0] refOp(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    case (f)
      6'd36: refOp = {1'b0, 32'd0, a & b};
      6'd37: refOp = {1'b0, 32'd0, a | b};
      6'd32: refOp = {1'b0, 32'd0, a + b};
      6'd34: refOp = {1'b0, 32'd0, a - b};
      6'd42: refOp = {1'b0, 32'd0, (($signed(a) < $signed(b)) ? 32'd1 : 32'd0)};
      6'd2:  refOp = {1'b0, 32'd0, a >> b[4:0]};
      6'd25: begin
        prod  = 64'(a) * 64'(b);
        refOp = {1'b0, prod};
      end
      6'd27: refOp = {1'b0, a % b, a / b};
      default: refOp = {1'b1, 64'd0};
    endcase
  endfunction

  // Presents one request, traces alu_signal until the response, checks it, then retires it.
  task automatic runOp(input string name, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expHi, input logic [31:0] expLo, input logic expErr, input int hold);
    int   guard;
    int   lat;
    int   fCount;
    int   fFirst;
    int   hiAt;
    int   loAt;
    int   other;
    logic isMulOp;
    logic [5:0] sig;
    isMulOp = ((f == 6'd25) || (f == 6'd27)) && !expErr;
    bus.rsp_ready = (hold == 0);
    bus.req_funct = f;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_valid = 1'b1;
    guard = 0;
    while ((bus.req_ready !== 1'b1) && (guard < 100)) begin
      @(negedge clk);
      guard++;
    end
    check($sformatf("%s req_ready", name), 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check($sformatf("%s dataA", name), 64'(bus.alu_dataA), 64'(a));
    check($sformatf("%s dataB", name), 64'(bus.alu_dataB), 64'(b));
    lat = 0; fCount = 0; fFirst = 0; hiAt = 0; loAt = 0; other = 0;
    for (int k = 1; (k <= 60) && (lat == 0); k++) begin
      sig = bus.alu_signal;
      if ((sig == f) && (sig != 6'd0)) begin
        fCount++;
        if (fFirst == 0) fFirst = k;
      end else if (sig == 6'd16) begin
        if (hiAt == 0) hiAt = k;
      end else if (sig == 6'd18) begin
        if (loAt == 0) loAt = k;
      end else if (sig != 6'd0) begin
        other++;
      end
      if (bus.rsp_valid === 1'b1) lat = k;
      else @(negedge clk);
    end
    check($sformatf("%s latency", name), 64'(lat),
          64'(expErr ? 1 : (isMulOp ? MUL + 3 + 2 * LAT : 2 + LAT)));
    check($sformatf("%s funct cycles", name), 64'(fCount), 64'(expErr ? 0 : (isMulOp ? MUL : 1)));
    check($sformatf("%s funct first", name), 64'(fFirst), 64'(expErr ? 0 : 1));
    check($sformatf("%s mfhi cycle", name), 64'(hiAt), 64'(isMulOp ? MUL + 1 : 0));
    check($sformatf("%s mflo cycle", name), 64'(loAt), 64'(isMulOp ? MUL + 2 + LAT : 0));
    check($sformatf("%s stray signal", name), 64'(other), 64'd0);
    check($sformatf("%s rsp_hi", name), 64'(bus.rsp_hi), 64'(expHi));
    check($sformatf("%s rsp_lo", name), 64'(bus.rsp_lo), 64'(expLo));
    check($sformatf("%s rsp_err", name), 64'(bus.rsp_err), 64'(expErr));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check($sformatf("%s held valid", name), 64'(bus.rsp_valid), 64'd1);
      check($sformatf("%s held lo", name), 64'(bus.rsp_lo), 64'(expLo));
      check($sformatf("%s held req_ready", name), 64'(bus.req_ready), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check($sformatf("%s valid after hs", name), 64'(bus.rsp_valid), 64'd0);
    check($sformatf("%s idle ready", name), 64'(bus.req_ready), 64'd1);
    check($sformatf("%s err cleared", name), 64'(bus.rsp_err), 64'd0);
  endtask

  typedef struct {
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
    logic        expErr;
    int          hold;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [5:0]  ops [10];
    logic [5:0]  f;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [64:0] expv;
    int          rvCount;

    vecs[0] = '{6'd32, 32'd5,          32'd7,      32'd0, 32'd12,         1'b0, 0};
    vecs[1] = '{6'd25, 32'hFFFF_FFFF,  32'd2,      32'd1, 32'hFFFF_FFFE,  1'b0, 0};
    vecs[2] = '{6'd34, 32'd3,          32'd5,      32'd0, 32'hFFFF_FFFE,  1'b0, 10};
    vecs[3] = '{6'h3F, 32'd1,          32'd2,      32'd0, 32'd0,          1'b1, 0};
    vecs[4] = '{6'd36, 32'h0000_F0F0,  32'h0000_FF00, 32'd0, 32'h0000_F000, 1'b0, 0};
    vecs[5] = '{6'd37, 32'd1,          32'd2,      32'd0, 32'd3,          1'b0, 2};
    vecs[6] = '{6'd42, 32'hFFFF_FFFF,  32'd1,      32'd0, 32'd1,          1'b0, 0};
    vecs[7] = '{6'd27, 32'd100,        32'd7,      32'd2, 32'd14,         1'b0, 1};
    vecs[8] = '{6'd2,  32'h8000_0000,  32'd4,      32'd0, 32'h0800_0000,  1'b0, 0};
    vecs[9] = '{6'd16, 32'd9,          32'd9,      32'd0, 32'd0,          1'b1, 3};

    ops[0] = 6'd36; ops[1] = 6'd37; ops[2] = 6'd32; ops[3] = 6'd34; ops[4] = 6'd42;
    ops[5] = 6'd2;  ops[6] = 6'd25; ops[7] = 6'd27; ops[8] = 6'd0;  ops[9] = 6'd63;

    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_funct = 6'd0;
    bus.req_a     = 32'd0;
    bus.req_b     = 32'd0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset req_ready", 64'(bus.req_ready), 64'd0);
    check("reset rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("reset alu_signal", 64'(bus.alu_signal), 64'd0);
    check("reset rsp_hi", 64'(bus.rsp_hi), 64'd0);
    check("reset rsp_lo", 64'(bus.rsp_lo), 64'd0);
    check("reset rsp_err", 64'(bus.rsp_err), 64'd0);
    check("reset dataA", 64'(bus.alu_dataA), 64'd0);
    check("reset dataB", 64'(bus.alu_dataB), 64'd0);
    reset = 1'b0;
    #1;
    check("post-reset req_ready", 64'(bus.req_ready), 64'd1);
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      runOp($sformatf("vec%0d", i), vecs[i].funct, vecs[i].a, vecs[i].b,
            vecs[i].expHi, vecs[i].expLo, vecs[i].expErr, vecs[i].hold);
    end

    // Reset pulse during MUL_RUN counter 10: op is dropped, no response.
    bus.rsp_ready = 1'b1;
    bus.req_funct = 6'd25;
    bus.req_a     = 32'hFFFF_FFFF;
    bus.req_b     = 32'd3;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("abort pre signal", 64'(bus.alu_signal), 64'd25);
    reset = 1'b1;
    #1;
    check("abort alu_signal", 64'(bus.alu_signal), 64'd0);
    check("abort rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("abort req_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort release ready", 64'(bus.req_ready), 64'd1);
    rvCount = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) rvCount++;
      if (bus.alu_signal !== 6'd0) rvCount++;
    end
    check("abort no response", 64'(rvCount), 64'd0);

`ifdef ALU_SEQ_OVERLAP_EN
    // Back-to-back: second request taken on the first response handshake edge.
    bus.rsp_ready = 1'b1;
    bus.req_funct = 6'd36;
    bus.req_a     = 32'h0000_F0F0;
    bus.req_b     = 32'h0000_FF00;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    rvCount = 0;
    while ((bus.rsp_valid !== 1'b1) && (rvCount < 20)) begin
      @(negedge clk);
      rvCount++;
    end
    check("ovl first lo", 64'(bus.rsp_lo), 64'h0000_F000);
    bus.req_funct = 6'd37;
    bus.req_a     = 32'd1;
    bus.req_b     = 32'd2;
    bus.req_valid = 1'b1;
    #1;
    check("ovl ready in resp", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("ovl issue signal", 64'(bus.alu_signal), 64'd37);
    check("ovl valid gap", 64'(bus.rsp_valid), 64'd0);
    repeat (2) @(negedge clk);
    check("ovl second valid", 64'(bus.rsp_valid), 64'd1);
    check("ovl second lo", 64'(bus.rsp_lo), 64'd3);
    @(negedge clk);
    check("ovl back idle", 64'(bus.req_ready), 64'd1);
`endif

    for (int i = 0; i < 40; i++) begin
      f  = ops[$urandom_range(0, 9)];
      ra = $urandom;
      rb = $urandom;
      if (($urandom_range(0, 3) == 0)) rb = rb & 32'h0000_001F;
      if ((f == 6'd27) && (rb == 32'd0)) rb = 32'd1;
      expv = refOp(f, ra, rb);
      runOp($sformatf("rnd%0d", i), f, ra, rb, expv[63:32], expv[31:0], expv[64],
            int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failed);
    $finish;
  end

endmodule
